// File: rtl/divisor_frecuencia_param.sv
// Purpose: parametrised clock divider producing a 50% clk_out, a tick pulse and a 7-seg digit scan.
// Latency: all outputs registered; tick/clk_out/digit_sel update the cycle after a terminal count.
// Backpressure: none; div_load is always accepted and acknowledged with div_ack one cycle later.
module divisor_frecuencia_param #(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned DIV_DEFAULT = 208332,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  div_load,
  input  logic [WIDTH-1:0]      div_value,
  output logic                  div_ack,
  output logic                  clk_out,
  output logic                  tick,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] anodo
);

  localparam logic [WIDTH-1:0]      DIV_RST   = WIDTH'(DIV_DEFAULT);
  localparam logic [SEL_W-1:0]      SEL_LAST  = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODO_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0]      cuenta_q, cuenta_d;
  logic [WIDTH-1:0]      div_active_q, div_active_d;
  logic [WIDTH-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  clk_out_q, clk_out_d;
  logic                  tick_q, tick_d;
  logic                  div_ack_q, div_ack_d;
  logic [SEL_W-1:0]      digit_sel_q, digit_sel_d;
  logic [NUM_DIGITS-1:0] anodo_q, anodo_d;
  logic                  terminal;

  // Next-state: counting, terminal events, divisor reload and the load handshake.
  always_comb begin
    cuenta_d     = cuenta_q;
    div_active_d = div_active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    digit_sel_d  = digit_sel_q;
    div_ack_d    = div_load;
    terminal     = (cuenta_q == div_active_q);

    if (enable) begin
      if (terminal) begin
        cuenta_d    = '0;
        clk_out_d   = ~clk_out_q;
        tick_d      = 1'b1;
        digit_sel_d = (digit_sel_q == SEL_LAST) ? '0 : digit_sel_q + SEL_W'(1);
        // A pending divisor only takes effect here, at a period boundary.
        if (pending_q) begin
          div_active_d = shadow_q;
          pending_d    = 1'b0;
        end
      end else begin
        cuenta_d = cuenta_q + WIDTH'(1);
      end
    end else if (pending_q) begin
      // Frozen: no period is running, so the new divisor can apply at once.
      div_active_d = shadow_q;
      cuenta_d     = '0;
      pending_d    = 1'b0;
    end

    // A load arriving now overrides any clear above; it is applied at a later boundary.
    if (div_load) begin
      shadow_d  = div_value;
      pending_d = 1'b1;
    end

    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      anodo_d[i] = (digit_sel_d != SEL_W'(i));
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q     <= '0;
      div_active_q <= DIV_RST;
      shadow_q     <= DIV_RST;
      pending_q    <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      div_ack_q    <= 1'b0;
      digit_sel_q  <= '0;
      anodo_q      <= ANODO_RST;
    end else begin
      cuenta_q     <= cuenta_d;
      div_active_q <= div_active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      div_ack_q    <= div_ack_d;
      digit_sel_q  <= digit_sel_d;
      anodo_q      <= anodo_d;
    end
  end

  assign div_ack   = div_ack_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign digit_sel = digit_sel_q;
  assign anodo     = anodo_q;

endmodule

// File: tb/tb_divisor_frecuencia_param.sv
// Purpose: randomized + directed scoreboard bench for divisor_frecuencia_param.
// Latency: expected outputs are predicted one clock ahead and compared after each edge.
// Backpressure: not applicable; the monitor compares every cycle an expectation is queued.
module tb_divisor_frecuencia_param;

  localparam int W   = 8;
  localparam int DEF = 4;
  localparam int ND  = 4;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          div_load = 1'b0;
  logic [W-1:0]  div_value = '0;
  logic          div_ack;
  logic          clk_out;
  logic          tick;
  logic [SW-1:0] digit_sel;
  logic [ND-1:0] anodo;

  divisor_frecuencia_param #(
    .WIDTH(W), .DIV_DEFAULT(DEF), .NUM_DIGITS(ND), .SEL_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div_load(div_load),
    .div_value(div_value), .div_ack(div_ack), .clk_out(clk_out),
    .tick(tick), .digit_sel(digit_sel), .anodo(anodo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ack;
    logic          co;
    logic          tk;
    logic [SW-1:0] sel;
    logic [ND-1:0] an;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: counts position in the period and total terminal events since reset.
  int m_cnt = 0, m_div = DEF, m_shadow = DEF, m_terms = 0;
  bit m_pend = 0, m_tick = 0, m_ack = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model and queue the expected outputs.
  task automatic drive(input bit r, input bit e, input bit l, input int v);
    exp_t x;
    logic [ND-1:0] one;
    int sel;
    @(posedge clk);
    #2;
    reset = r; enable = e; div_load = l; div_value = W'(v);
    if (r) begin
      m_cnt = 0; m_div = DEF; m_shadow = DEF; m_pend = 0;
      m_terms = 0; m_tick = 0; m_ack = 0;
    end else begin
      bit np;
      np = m_pend;
      m_ack = l;
      m_tick = 0;
      if (e) begin
        if (m_cnt == m_div) begin
          m_terms++;
          m_tick = 1;
          m_cnt = 0;
          if (m_pend) begin m_div = m_shadow; np = 0; end
        end else begin
          m_cnt++;
        end
      end else if (m_pend) begin
        m_div = m_shadow; m_cnt = 0; np = 0;
      end
      if (l) begin m_shadow = v; np = 1; end
      m_pend = np;
    end
    sel = m_terms % ND;
    one = 1;
    x.ack = m_ack;
    x.co  = m_terms[0];
    x.tk  = m_tick;
    x.sel = SW'(sel);
    x.an  = ~(one << sel);
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(0, e, 0, 0);
  endtask

  // Advance with enable=1 until the model counter reaches target; bounded.
  task automatic run_to_cnt(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 60) begin
      drive(0, 1, 0, 0);
      k++;
    end
    chk("reach_count", m_cnt, target);
  endtask

  // Load v and run until it has taken effect.
  task automatic settle_div(input int v);
    drive(0, 1, 1, v);
    for (int i = 0; i < 60 && m_pend; i++) drive(0, 1, 0, 0);
    chk("settle_pending", int'(m_pend), 0);
  endtask

  // Monitor: compares each registered output against the queued prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        chk("div_ack",   int'(div_ack),   int'(x.ack));
        chk("clk_out",   int'(clk_out),   int'(x.co));
        chk("tick",      int'(tick),      int'(x.tk));
        chk("digit_sel", int'(digit_sel), int'(x.sel));
        chk("anodo",     int'(anodo),     int'(x.an));
      end
    end
  end

  initial begin
    // Reset and default period of 5 cycles.
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    run(25, 1);

    // Runtime reload of 2 at cuenta=1.
    run_to_cnt(1);
    drive(0, 1, 1, 2);
    run(20, 1);

    // Coincident load and terminal.
    settle_div(4);
    run_to_cnt(4);
    drive(0, 1, 1, 1);
    run(20, 1);

    // Enable freeze, then a load while disabled.
    settle_div(4);
    run_to_cnt(2);
    run(7, 0);
    run(12, 1);
    drive(0, 0, 1, 3);
    run(4, 0);
    run(15, 1);

    // Divisor 0: tick every cycle.
    drive(0, 1, 1, 0);
    run(14, 1);

    // Level-held load, last value wins.
    drive(0, 1, 1, 5);
    drive(0, 1, 1, 6);
    drive(0, 1, 1, 2);
    run(20, 1);

    // Reset with a pending load and clk_out high.
    for (int i = 0; i < 40 && m_terms % 2 == 0; i++) drive(0, 1, 0, 0);
    chk("clk_out_high_before_reset", m_terms % 2, 1);
    drive(0, 1, 1, 1);
    drive(1, 1, 0, 0);
    run(20, 1);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 11) == 0, int'($urandom_range(0, 7)));
    end

    drive(0, 1, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
